// File: rtl/Tipos.sv
// Shared types and constants for the keypad entry block: key codes, BCD display glyphs,
// the display packet type, the scan FSM state type and keypad decode helpers.
package Tipos;

  localparam logic [3:0] KEY_CLEAR   = 4'hE;
  localparam logic [3:0] KEY_CONFIRM = 4'hF;
  localparam logic [3:0] BCD_BLANK   = 4'hB;
  localparam logic [3:0] BCD_DASH    = 4'hA;

  typedef struct packed {
    logic [3:0] bcd5;
    logic [3:0] bcd4;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } bcdPac_t;

  typedef enum logic [2:0] {
    SCAN,
    DEB_PRESS,
    EMIT,
    WAIT_REL,
    DEB_REL
  } scan_state_e;

  // Column 3 has no key; callers must filter it before using the code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    unique case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_CLEAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_CONFIRM;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0]) begin
      idx = 2'd0;
    end else if (!col[1]) begin
      idx = 2'd1;
    end else if (!col[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row scanner and press/release debounce FSM for a 4x4 active-low matrix keypad.
// Emits a one-cycle key_valid with the decoded key_code per debounced press.
module keypad_scan
  import Tipos::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                    : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      row       <= 4'b1110;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (col != 4'hF) begin
            col_idx <= lowest_low(col);
            cnt     <= '0;
            state   <= DEB_PRESS;
          end else if (cnt == SCAN_LAST) begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= {row[2:0], row[3]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (col[col_idx]) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= EMIT;
            // key_valid is registered so it is high exactly during EMIT
            if (col_idx != 2'd3) begin
              key_valid <= 1'b1;
              key_code  <= key_map(row_idx, col_idx);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (col == 4'hF) begin
            cnt   <= '0;
            state <= DEB_REL;
          end
        end
        DEB_REL: begin
          if (col != 4'hF) begin
            state <= WAIT_REL;
          end else if (cnt == DEB_LAST) begin
            cnt     <= '0;
            row     <= 4'b1110;
            row_idx <= 2'd0;
            state   <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad code entry: six-digit shift buffer fed by keypad_scan, with clear ('*') and
// confirm ('#'). Define KEYPAD_MASK_EN to show all occupied digits but BCD0 as dashes.
module keypad_entry
  import Tipos::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output bcdPac_t    bcd_packet,
  output logic       enable_o,
  output logic       code_valid,
  output logic [2:0] code_len
);

  localparam logic [23:0] ALL_BLANK = {6{BCD_BLANK}};

  logic [23:0] buf_q, buf_d;
  logic [2:0]  len_q, len_d;
  logic        en_q;
  logic [23:0] disp;

  keypad_scan #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always_comb begin
    buf_d = buf_q;
    len_d = len_q;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (len_q < 3'd6) begin
          buf_d = {buf_q[19:0], key_code};
          len_d = len_q + 3'd1;
        end
      end else if (key_code == KEY_CLEAR ||
                   (key_code == KEY_CONFIRM && len_q != 3'd0)) begin
        buf_d = ALL_BLANK;
        len_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= ALL_BLANK;
      len_q <= 3'd0;
      en_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      len_q <= len_d;
      en_q  <= (buf_d != buf_q);
    end
  end

  always_comb begin
    disp = buf_q;
`ifdef KEYPAD_MASK_EN
    for (int i = 1; i < 6; i++) begin
      if (3'(i) < len_q) begin
        disp[4*i +: 4] = BCD_DASH;
      end
    end
`endif
  end

  assign bcd_packet = bcdPac_t'(disp);
  assign enable_o   = en_q;
  assign code_len   = len_q;
  // Uses the pre-clear length so it fires in the EMIT cycle itself
  assign code_valid = key_valid && (key_code == KEY_CONFIRM) && (len_q != 3'd0);

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives col from row, stimulus pushes
// expected key responses, and a monitor checks each key_valid and the following cycle.
module tb_keypad_entry;
  import Tipos::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  bcdPac_t    bcd_packet;
  logic       enable_o;
  logic       code_valid;
  logic [2:0] code_len;

  keypad_entry #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .row        (row),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .bcd_packet (bcd_packet),
    .enable_o   (enable_o),
    .code_valid (code_valid),
    .code_len   (code_len)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven low.
  logic       pressed = 1'b0;
  logic [1:0] pr = 2'd0;
  logic [1:0] pc = 2'd0;
  always_comb begin
    col = 4'hF;
    if (pressed && !row[pr]) col[pc] = 1'b0;
  end

  typedef struct {
    logic [3:0]  code;
    logic        cv;
    logic [23:0] bcd;
    logic [2:0]  len;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   en_seen = 0;
  int   en_exp = 0;
  int   cv_seen = 0;
  int   cv_exp = 0;

  logic [23:0] m_buf = 24'hBBBBBB;
  int          m_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] m_disp();
    logic [23:0] d;
    d = m_buf;
`ifdef KEYPAD_MASK_EN
    for (int i = 1; i < 6; i++) if (i < m_len) d[4*i +: 4] = 4'hA;
`endif
    return d;
  endfunction

  // Monitor: pop on each key_valid, then check buffer/len/enable the next cycle.
  initial begin
    exp_t        e;
    logic        pend;
    logic [23:0] bp;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (enable_o) en_seen++;
        if (code_valid) cv_seen++;
        bp = bcd_packet;
        if (key_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_key_valid", {28'd0, key_code}, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("key_code", {28'd0, key_code}, {28'd0, e.code});
            chk("code_valid", {31'd0, code_valid}, {31'd0, e.cv});
            pend = 1'b1;
          end
        end else if (pend) begin
          chk("bcd_packet", {8'd0, bp}, {8'd0, e.bcd});
          chk("code_len", {29'd0, code_len}, {29'd0, e.len});
          chk("enable_o", {31'd0, enable_o}, {31'd0, e.en});
          pend = 1'b0;
        end
      end
    end
  end

  task automatic push_expect(input logic [3:0] code);
    exp_t        e;
    logic [23:0] old;
    old  = m_buf;
    e.cv = 1'b0;
    if (code <= 4'd9) begin
      if (m_len < 6) begin
        m_buf = {m_buf[19:0], code};
        m_len++;
      end
    end else if (code == 4'hE) begin
      m_buf = 24'hBBBBBB;
      m_len = 0;
    end else if (m_len > 0) begin
      e.cv  = 1'b1;
      m_buf = 24'hBBBBBB;
      m_len = 0;
    end
    e.code = code;
    e.bcd  = m_disp();
    e.len  = 3'(m_len);
    e.en   = (m_buf != old);
    if (e.en) en_exp++;
    if (e.cv) cv_exp++;
    exp_q.push_back(e);
  endtask

  task automatic glitch(input int n);
    for (int i = 0; i < n; i++) begin
      pressed = 1'b1;
      repeat (3) @(negedge clk);
      pressed = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Press (r,c); when code is valid expect one key, else expect nothing.
  task automatic press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                       input bit expect_key, input int glitches, input int hold);
    int n;
    pr = r;
    pc = c;
    if (expect_key) push_expect(code);
    glitch(glitches);
    pressed = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("key_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
    glitch(glitches);
    pressed = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic digit(input int d);
    if (d == 0) press(2'd3, 2'd1, 4'd0, 1'b1, 0, 3);
    else press(2'((d - 1) / 3), 2'((d - 1) % 3), 4'(d), 1'b1, 0, 3);
  endtask

  task automatic check_reset(input string tag);
    logic [23:0] bp;
    bp = bcd_packet;
    chk({tag, "_row"}, {28'd0, row}, 32'hE);
    chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_key_code"}, {28'd0, key_code}, 32'd0);
    chk({tag, "_code_valid"}, {31'd0, code_valid}, 32'd0);
    chk({tag, "_code_len"}, {29'd0, code_len}, 32'd0);
    chk({tag, "_enable_o"}, {31'd0, enable_o}, 32'd0);
    chk({tag, "_bcd"}, {8'd0, bp}, 32'h00BBBBBB);
  endtask

  task automatic check_bcd(input string name, input logic [23:0] req);
    logic [23:0] bp;
    @(negedge clk);
    bp = bcd_packet;
    chk(name, {8'd0, bp}, {8'd0, req});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single key 5, then a glitchy 7 held long with glitchy release
    press(2'd1, 2'd1, 4'd5, 1'b1, 0, 3);
    press(2'd2, 2'd0, 4'd7, 1'b1, 3, 100);
    press(2'd3, 2'd0, KEY_CLEAR, 1'b1, 0, 3);

    // Fill past capacity
    for (int d = 1; d <= 7; d++) digit(d);
`ifdef KEYPAD_MASK_EN
    check_bcd("full_buffer", 24'hAAAAA6);
`else
    check_bcd("full_buffer", 24'h123456);
`endif
    chk("full_len", {29'd0, code_len}, 32'd6);

    // Clear, enter 4 2, confirm; then confirm on empty
    press(2'd3, 2'd0, KEY_CLEAR, 1'b1, 0, 3);
    digit(4);
    digit(2);
    press(2'd3, 2'd2, KEY_CONFIRM, 1'b1, 0, 3);
    check_bcd("after_confirm", 24'hBBBBBB);
    press(2'd3, 2'd2, KEY_CONFIRM, 1'b1, 0, 3);
    press(2'd1, 2'd3, 4'h0, 1'b0, 0, 40);

    // Reset during press debounce with a non-empty buffer
    digit(3);
    pr = 2'd0;
    pc = 2'd0;
    pressed = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!row[0]) break;
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    m_buf = 24'hBBBBBB;
    m_len = 0;
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_len", {29'd0, code_len}, 32'd0);

    digit(7);
    digit(8);
    digit(9);
`ifdef KEYPAD_MASK_EN
    check_bcd("entry_789", 24'hBBBAA9);
`else
    check_bcd("entry_789", 24'hBBB789);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("enable_pulses", 32'(en_seen), 32'(en_exp));
    chk("code_valid_pulses", 32'(cv_seen), 32'(cv_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter SCAN_CYCLES, default 1000: clk cycles each row stays driven during scan.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required for press or release.
REQ-003 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port col  input  4  keypad columns, active-low, pre-synchronized.
REQ-006 The block SHALL have port row  output  4  keypad rows, one-hot active-low drive.
REQ-007 The block SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-008 The block SHALL have port key_code  output  4  code of last accepted key: 0-9 digits, 4'hE '*', 4'hF '#'.
REQ-009 The block SHALL have port bcd_packet  output  bcdPac_t  six-digit entry buffer for display.
REQ-010 The block SHALL have port enable_o  output  1  one-cycle pulse, cycle after any bcd_packet change.
REQ-011 The block SHALL have port code_valid  output  1  one-cycle pulse on '#' with at least one digit entered.
REQ-012 The block SHALL have port code_len  output  3  digit count in buffer, 0-6.

Function
REQ-013 FSM states SHALL be SCAN, DEB_PRESS, EMIT, WAIT_REL, DEB_REL.
REQ-014 SCAN SHALL drive row[k] low for SCAN_CYCLES, then k+1, wrapping 3->0.
REQ-015 SCAN SHALL go to DEB_PRESS, row frozen, when any col bit is low; lowest-index low column is captured.
REQ-016 DEB_PRESS SHALL count while the captured column stays low, return to SCAN with counter cleared if it goes high, and go to EMIT at DEBOUNCE_CYCLES.
REQ-017 EMIT SHALL last one cycle, pulse key_valid, update key_code from the (row,col) map, then go to WAIT_REL.
REQ-018 Map SHALL be row0: 1 2 3 x, row1: 4 5 6 x, row2: 7 8 9 x, row3: * 0 # x; x (col3) SHALL be ignored, no key_valid.
REQ-019 WAIT_REL SHALL go to DEB_REL when all col bits are high; DEB_REL SHALL return to WAIT_REL on any low and go to SCAN (row 0) after DEBOUNCE_CYCLES high.
REQ-020 Digit with code_len<6 SHALL shift the buffer (BCD5<-BCD4 ... BCD1<-BCD0), load BCD0 with the digit, and increment code_len.
REQ-021 Digit with code_len=6 SHALL be discarded: no buffer change, no enable_o; key_valid still pulses.
REQ-022 '*' SHALL set all six BCD fields to 4'hB (blank) and code_len to 0.
REQ-023 '#' with code_len>0 SHALL pulse code_valid in the EMIT cycle, then clear as '*'; with code_len=0 it SHALL do nothing beyond key_valid.
REQ-024 enable_o SHALL pulse exactly one cycle after every cycle in which bcd_packet changed, including the clear after '#'.
REQ-025 Unused buffer positions SHALL always hold 4'hB.

Reset
REQ-026 On rst: state SCAN, row=4'b1110, counters 0, key_valid=0, key_code=0, code_valid=0, code_len=0, enable_o=0, all BCD fields 4'hB.
REQ-027 rst mid-debounce or mid-wait SHALL discard the key in progress; no pulse SHALL follow release of rst.

Configuration
REQ-028 With KEYPAD_MASK_EN defined, every occupied bcd_packet position except BCD0 SHALL read 4'hA (dash) while internal digits are kept; without it all positions SHALL show true digits.

Structure
REQ-029 bcdPac_t, KEY_CLEAR=4'hE, KEY_CONFIRM=4'hF, BCD_BLANK=4'hB, BCD_DASH=4'hA SHALL live in the shared Tipos package.
REQ-030 Row scan and debounce FSM SHALL be sub-module keypad_scan (outputs key_valid, key_code); keypad_entry SHALL hold the buffer logic.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-031 Press row1/col1 stable 8 cycles -> one key_valid, key_code=5; BCD0=5, code_len=1, enable_o next cycle.
REQ-032 Press with 3-cycle glitches before stable hold -> exactly one key_valid; held key -> no repeat until 8-cycle release.
REQ-033 Enter 1,2,3,4,5,6,7 -> BCD5..BCD0=1,2,3,4,5,6, code_len=6, seventh key gives key_valid without enable_o.
REQ-034 Enter 4,2 then '#' -> code_valid pulse, buffer all 4'hB, code_len=0, enable_o; '#' on empty -> no code_valid, no enable_o.
REQ-035 rst asserted during DEB_PRESS -> reset values, no key_valid after release of rst.
REQ-036 KEYPAD_MASK_EN, enter 7,8,9 -> BCD2=A, BCD1=A, BCD0=9, others B.
